alien_march_ctrl: RTL
=====================

ALIEN_MARCH_CTRL -- requirements
Module: alien_march_ctrl

Interface
REQ-001 Parameters (name, default, meaning): STEP_X, 8, columns per horizontal step; STEP_Y, 10, rows per drop; STEP_FRAMES, 32, frames per step; FAST_FRAMES, 8, frames per step when few aliens remain; FAST_THRESHOLD, 10, live count at or below which FAST_FRAMES applies; START_COL, 120, formation origin column; START_ROW, 40, formation origin row; LAND_ROW, 440, landing row.
REQ-002 Clk  in  1  system clock; all state changes on posedge.
REQ-003 Reset  in  1  reset, synchronous, active-high.
REQ-004 FrameTick  in  1  one-cycle pulse per video frame.
REQ-005 Restart  in  1  one-cycle pulse; reloads formation from CLEARED or LANDED.
REQ-006 BulletRow  in  9  bullet pixel row; BulletCol  in  10  bullet pixel column; BulletExists  in  1  bullet valid.
REQ-007 Aliens_Grid  out  50  live mask, bit index = row*10 + col (5 rows x 10 cols).
REQ-008 AliensRow  out  9 / AliensCol  out  10  formation top-left pixel.
REQ-009 BulletHit  out  1  one-cycle pulse per kill; AllDead  out  1  level; Landed  out  1  level.

Function
REQ-010 Geometry: cell 30x20, pitch 40x30; pixel (x,y) hits cell (c,r) iff dx=x-AliensCol>=0, dy=y-AliensRow>=0, c=dx/40<10, r=dy/30<5, dx%40<30, dy%30<20.
REQ-011 States: RUN_R, RUN_L, CLEARED, LANDED; reset state RUN_R.
REQ-012 Frame counter counts FrameTick; step fires on the tick bringing count to period (FAST_FRAMES if live count <= FAST_THRESHOLD, else STEP_FRAMES), counter then clears.
REQ-013 Extents use live columns/rows only: Lc/Rc = leftmost/rightmost live column, Bm = bottom live row.
REQ-014 RUN_R step: if AliensCol+40*Rc+30+STEP_X > 640 then AliensRow += STEP_Y, go RUN_L; else AliensCol += STEP_X.
REQ-015 RUN_L step: if AliensCol+40*Lc < STEP_X then AliensRow += STEP_Y, go RUN_R; else AliensCol -= STEP_X.
REQ-016 After any position update, if AliensRow+30*Bm+20 >= LAND_ROW then go LANDED next cycle.
REQ-017 Hit: in RUN_R/RUN_L, when BulletExists, hit lock clear, bullet in a live cell per REQ-010: clear that bit and pulse BulletHit on the next edge, set hit lock.
REQ-018 Hit lock clears on any cycle BulletExists=0; at most one kill per bullet.
REQ-019 Step and hit in the same cycle: both applied; hit decoded against pre-step position.
REQ-020 Grid becomes zero: go CLEARED next cycle; AllDead=1 in CLEARED. No steps or hits in CLEARED/LANDED; Landed=1 in LANDED.
REQ-021 Restart in CLEARED/LANDED: grid all ones, origin START_COL/START_ROW, counter 0, RUN_R. Ignored in RUN states.
REQ-022 Arithmetic at 11 bits unsigned, no wrap; outputs stay within 0..639 / 0..479.

Reset
REQ-023 On Reset: Aliens_Grid=50'h3_FFFF_FFFF_FFFF, AliensCol=START_COL, AliensRow=START_ROW, state RUN_R, frame counter 0, hit lock 0, BulletHit=0, AllDead=0, Landed=0.
REQ-024 Reset overrides Restart, FrameTick and hits in the same cycle.

Structure
REQ-025 Cell sizes, pitches, grid dimensions, screen size and the state encoding live in a shared invaders geometry package.
REQ-026 Point-to-cell decode (REQ-010) is sub-module alien_hit_locator: combinational, outputs hit flag and 6-bit index.
REQ-027 Live-extent and popcount logic is registered-free combinational within alien_march_ctrl.

Verification
REQ-028 Reset, 16 steps of 32 FrameTicks each -> AliensCol 120 to 248 by 8; 17th step -> AliensRow 50, AliensCol 248, state RUN_L.
REQ-029 Bullet (col 125,row 45) held 5 cycles -> bit 0 cleared, one BulletHit pulse; then (155,45) -> no hit (column gap).
REQ-030 Kill column 9 (bits 9,19,29,39,49) -> rightmost step limit extends: drop only when AliensCol > 282.
REQ-031 Kill down to 10 live -> step period becomes 8 FrameTicks.
REQ-032 Kill last alien -> AllDead=1 next cycle, steps frozen; Restart -> grid all ones, (120,40), AllDead=0.
REQ-033 Reset asserted mid-drop with coincident hit and FrameTick -> outputs equal REQ-023 values next cycle.

Source files
------------

// File: rtl/alien_march_ctrl_pkg.sv
// Shared invaders geometry: alien cell size and pitch, grid dimensions,
// screen size, the march FSM state encoding and a live-count helper.
// No ports; imported by alien_march_ctrl and alien_hit_locator.
package alien_march_ctrl_pkg;

    localparam int CELL_W     = 30;
    localparam int CELL_H     = 20;
    localparam int PITCH_X    = 40;
    localparam int PITCH_Y    = 30;
    localparam int GRID_COLS  = 10;
    localparam int GRID_ROWS  = 5;
    localparam int GRID_CELLS = GRID_COLS * GRID_ROWS;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;

    localparam logic [1:0] ST_RUN_R   = 2'd0;
    localparam logic [1:0] ST_RUN_L   = 2'd1;
    localparam logic [1:0] ST_CLEARED = 2'd2;
    localparam logic [1:0] ST_LANDED  = 2'd3;

    localparam logic [GRID_CELLS-1:0] GRID_FULL = '1;

    function automatic logic [5:0] live_count(input logic [GRID_CELLS-1:0] grid);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < GRID_CELLS; i++) begin
            if (grid[i]) n = n + 6'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/alien_march_ctrl_hit_locator.sv
// alien_hit_locator: combinational point-to-cell decode.
// Ports:
//   px_i / py_i         bullet pixel column / row
//   org_col_i/org_row_i formation top-left pixel
//   hit_o               point lies inside some cell body (liveness not checked)
//   idx_o               cell index, row*10 + col (valid only when hit_o)
module alien_hit_locator
    import alien_march_ctrl_pkg::*;
(
    input  logic [9:0] px_i,
    input  logic [8:0] py_i,
    input  logic [9:0] org_col_i,
    input  logic [8:0] org_row_i,
    output logic       hit_o,
    output logic [5:0] idx_o
);

    logic [10:0] dx, dy;
    logic [10:0] cell_c, cell_r;
    logic [10:0] off_x, off_y;
    logic        right_of, below;

    always_comb begin
        right_of = (px_i >= org_col_i);
        below    = (py_i >= org_row_i);
        // Offsets wrap when the point is above/left of the origin; the
        // right_of/below qualifiers reject those cases.
        dx       = 11'(px_i) - 11'(org_col_i);
        dy       = 11'(py_i) - 11'(org_row_i);
        cell_c   = dx / 11'(PITCH_X);
        cell_r   = dy / 11'(PITCH_Y);
        off_x    = dx % 11'(PITCH_X);
        off_y    = dy % 11'(PITCH_Y);
        hit_o    = right_of && below
                && (cell_c < 11'(GRID_COLS)) && (cell_r < 11'(GRID_ROWS))
                && (off_x < 11'(CELL_W)) && (off_y < 11'(CELL_H));
        idx_o    = 6'(cell_r * 11'(GRID_COLS) + cell_c);
    end

endmodule

// File: rtl/alien_march_ctrl.sv
// alien_march_ctrl: marches a 5x10 alien formation across the screen,
// drops a row at each edge, removes aliens hit by the player bullet and
// reports cleared / landed.
// Ports:
//   Clk, Reset (sync, active-high), FrameTick (per-frame pulse),
//   Restart (reload from CLEARED/LANDED), BulletRow/BulletCol/BulletExists,
//   Aliens_Grid (live mask, bit = row*10+col), AliensRow/AliensCol (origin),
//   BulletHit (kill pulse), AllDead, Landed.
//
// state      | meaning
// RUN_R      | marching right
// RUN_L      | marching left
// CLEARED    | every alien destroyed, frozen until Restart
// LANDED     | formation reached LAND_ROW, frozen until Restart
module alien_march_ctrl
    import alien_march_ctrl_pkg::*;
#(
    parameter int STEP_X         = 8,
    parameter int STEP_Y         = 10,
    parameter int STEP_FRAMES    = 32,
    parameter int FAST_FRAMES    = 8,
    parameter int FAST_THRESHOLD = 10,
    parameter int START_COL      = 120,
    parameter int START_ROW      = 40,
    parameter int LAND_ROW       = 440
)
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  FrameTick,
    input  logic                  Restart,
    input  logic [8:0]            BulletRow,
    input  logic [9:0]            BulletCol,
    input  logic                  BulletExists,
    output logic [GRID_CELLS-1:0] Aliens_Grid,
    output logic [8:0]            AliensRow,
    output logic [9:0]            AliensCol,
    output logic                  BulletHit,
    output logic                  AllDead,
    output logic                  Landed
);

    logic [1:0]            state_q, state_d;
    logic [GRID_CELLS-1:0] grid_q, grid_d;
    logic [9:0]            col_q, col_d;
    logic [8:0]            row_q, row_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  lock_q, lock_d;
    logic                  hit_q, hit_d;

    logic [GRID_COLS-1:0]  col_live;
    logic [GRID_ROWS-1:0]  row_live;
    logic [3:0]            lc, rc;
    logic [2:0]            bm;
    logic [5:0]            live_n;
    logic [7:0]            period;
    logic [7:0]            cnt_inc;
    logic                  step_due;
    logic [10:0]           right_edge, left_edge, bottom_edge;
    logic                  land_now;
    logic                  loc_hit;
    logic [5:0]            loc_idx;
    logic                  hit_fire;

    alien_hit_locator u_locator (
        .px_i      (BulletCol),
        .py_i      (BulletRow),
        .org_col_i (col_q),
        .org_row_i (row_q),
        .hit_o     (loc_hit),
        .idx_o     (loc_idx)
    );

    // Live extents: only columns/rows that still hold an alien bound the march.
    always_comb begin
        col_live = '0;
        row_live = '0;
        for (int r = 0; r < GRID_ROWS; r++) begin
            for (int c = 0; c < GRID_COLS; c++) begin
                if (grid_q[r*GRID_COLS + c]) begin
                    col_live[c] = 1'b1;
                    row_live[r] = 1'b1;
                end
            end
        end
        lc = '0;
        rc = '0;
        bm = '0;
        for (int c = GRID_COLS - 1; c >= 0; c--) begin
            if (col_live[c]) lc = 4'(c);
        end
        for (int c = 0; c < GRID_COLS; c++) begin
            if (col_live[c]) rc = 4'(c);
        end
        for (int r = 0; r < GRID_ROWS; r++) begin
            if (row_live[r]) bm = 3'(r);
        end
    end

    always_comb begin
        live_n      = live_count(grid_q);
        period      = (live_n <= 6'(FAST_THRESHOLD)) ? 8'(FAST_FRAMES) : 8'(STEP_FRAMES);
        cnt_inc     = cnt_q + 8'd1;
        // >= rather than == so a period shrinking below the current count
        // still fires on the next tick instead of wrapping the counter.
        step_due    = FrameTick && (cnt_inc >= period);
        right_edge  = 11'(col_q) + 11'(PITCH_X) * 11'(rc) + 11'(CELL_W) + 11'(STEP_X);
        left_edge   = 11'(col_q) + 11'(PITCH_X) * 11'(lc);
        bottom_edge = 11'(row_q) + 11'(PITCH_Y) * 11'(bm) + 11'(CELL_H);
        land_now    = (bottom_edge >= 11'(LAND_ROW));
        hit_fire    = BulletExists && !lock_q && loc_hit && grid_q[loc_idx];
    end

    always_comb begin
        state_d = state_q;
        grid_d  = grid_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        lock_d  = BulletExists ? lock_q : 1'b0;
        hit_d   = 1'b0;

        case (state_q)
            ST_RUN_R, ST_RUN_L: begin
                if (grid_q == '0) begin
                    state_d = ST_CLEARED;
                end else if (land_now) begin
                    state_d = ST_LANDED;
                end else begin
                    if (FrameTick) begin
                        cnt_d = step_due ? 8'd0 : cnt_inc;
                    end
                    if (step_due) begin
                        if (state_q == ST_RUN_R) begin
                            if (right_edge > 11'(SCREEN_W)) begin
                                row_d   = row_q + 9'(STEP_Y);
                                state_d = ST_RUN_L;
                            end else begin
                                col_d = col_q + 10'(STEP_X);
                            end
                        end else begin
                            if (left_edge < 11'(STEP_X)) begin
                                row_d   = row_q + 9'(STEP_Y);
                                state_d = ST_RUN_R;
                            end else begin
                                // Saturate: a dead left column can let the
                                // origin sit left of STEP_X.
                                col_d = (col_q >= 10'(STEP_X)) ? (col_q - 10'(STEP_X)) : 10'd0;
                            end
                        end
                    end
                    if (hit_fire) begin
                        grid_d[loc_idx] = 1'b0;
                        hit_d           = 1'b1;
                        lock_d          = 1'b1;
                    end
                end
            end
            ST_CLEARED, ST_LANDED: begin
                if (Restart) begin
                    grid_d  = GRID_FULL;
                    col_d   = 10'(START_COL);
                    row_d   = 9'(START_ROW);
                    cnt_d   = 8'd0;
                    state_d = ST_RUN_R;
                end
            end
            default: state_d = ST_RUN_R;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_RUN_R;
            grid_q  <= GRID_FULL;
            col_q   <= 10'(START_COL);
            row_q   <= 9'(START_ROW);
            cnt_q   <= 8'd0;
            lock_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
            hit_q   <= hit_d;
        end
    end

    assign Aliens_Grid = grid_q;
    assign AliensRow   = row_q;
    assign AliensCol   = col_q;
    assign BulletHit   = hit_q;
    assign AllDead     = (state_q == ST_CLEARED);
    assign Landed      = (state_q == ST_LANDED);

endmodule
